// File: rtl/vga_pkg.sv
// vga_pkg: raster constants and lock-state type shared by the vga_in receiver.
//   Raster: 1680 x 828 total, 1280 x 800 active, active window starts at
//   sample 336 after the hsync fall and at line 27 after the frame start.
package vga_pkg;

  localparam int H_TOTAL     = 1680;
  localparam int V_TOTAL     = 828;
  localparam int H_SYNC      = 136;
  localparam int V_SYNC      = 3;
  localparam int H_START     = 336;
  localparam int V_START     = 27;
  localparam int H_ACTIVE    = 1280;
  localparam int V_ACTIVE    = 800;
  localparam int LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync line and flags its edges.
//   clk, rst : pixel clock, synchronous active-high reset
//   sig_i    : raw sync input from the pins
//   rise_o   : current registered sample is 1, previous was 0
//   fall_o   : current registered sample is 0, previous was 1
// Both flops clear on reset, so a line held low coming out of reset does
// not produce a spurious falling edge.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic prev_q;

  // Input register followed by the previous-sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= sig_i;
      prev_q <= s1_q;
    end
  end

  assign rise_o = s1_q & ~prev_q;
  assign fall_o = ~s1_q & prev_q;

endmodule

// File: rtl/vga_in.sv
// vga_in: receive-side VGA raster decoder.
//   Samples hsync (active-low) / vsync (active-high) / 4:4:4 RGB, recovers
//   pixel coordinates, checks line and frame lengths and declares lock after
//   LOCK_FRAMES consecutive clean frames.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   hsync, vsync        sync lines
//   pix_r/g/b           pixel colour
//   cap_x/cap_y/cap_rgb active coordinates and colour (0 outside the window)
//   cap_valid           active pixel while locked
//   frame_start         pulse with pixel (0,0)
//   locked              raster lock
//   err_h / err_v       bad line length / bad frame length pulses
//   line_len            last measured line length
//   blank_err           non-zero RGB in blanking while locked
// Every output lags the pins by two cycles (input register, output register).
// Optional feature macro: VGA_IN_BLANK_CHECK_EN enables the blanking check;
// without it blank_err is tied low.
// Raster parameters default to the package's 1280x800 raster and may be
// overridden for a smaller raster with the same structure.
module vga_in
  import vga_pkg::*;
#(
  parameter int P_H_TOTAL     = H_TOTAL,
  parameter int P_V_TOTAL     = V_TOTAL,
  parameter int P_H_START     = H_START,
  parameter int P_H_ACTIVE    = H_ACTIVE,
  parameter int P_V_START     = V_START,
  parameter int P_V_ACTIVE    = V_ACTIVE,
  parameter int P_LOCK_FRAMES = LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  pix_r,
  input  logic [3:0]  pix_g,
  input  logic [3:0]  pix_b,
  output logic [10:0] cap_x,
  output logic [9:0]  cap_y,
  output logic [11:0] cap_rgb,
  output logic        cap_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [10:0] line_len,
  output logic        blank_err
);

  logic        hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
  logic        unused_s;
  logic [11:0] rgb_q;
  logic [10:0] rx_h_q, rx_h_d;
  logic [9:0]  rx_v_q, rx_v_d;
  logic        vpend_q, vpend_d;
  logic [3:0]  good_q, good_d;
  lock_state_t state_q, state_d;
  logic [11:0] h_len_s;
  logic [10:0] v_len_s;
  logic        err_h_raw_s, err_v_raw_s, fstart_s;
  logic        err_h_s, err_v_s;
  logic        lock_s, h_win_s, v_win_s, valid_s, blank_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;

  vga_sync_edge u_hs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (hsync),
    .rise_o (hs_rise_s),
    .fall_o (hs_fall_s)
  );

  vga_sync_edge u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (vsync),
    .rise_o (vs_rise_s),
    .fall_o (vs_fall_s)
  );

  // Only the hsync fall and the vsync rise carry timing information
  assign unused_s = hs_rise_s | vs_fall_s;

  // Stage-1 colour register, aligned with the sync edge detectors
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= 12'd0;
    end else begin
      rgb_q <= {pix_r, pix_g, pix_b};
    end
  end

  // Horizontal/vertical counters, frame-start detection and length checks
  always_comb begin
    rx_h_d      = rx_h_q;
    rx_v_d      = rx_v_q;
    vpend_d     = vpend_q | vs_rise_s;   // a rise on the hsync-fall sample still counts
    h_len_s     = {1'b0, rx_h_q} + 12'd1;
    v_len_s     = {1'b0, rx_v_q} + 11'd1;
    err_h_raw_s = 1'b0;
    err_v_raw_s = 1'b0;
    fstart_s    = 1'b0;
    if (hs_fall_s) begin
      rx_h_d      = 11'd0;
      err_h_raw_s = (h_len_s != 12'(P_H_TOTAL));
      if (vpend_d) begin
        rx_v_d      = 10'd0;
        vpend_d     = 1'b0;
        fstart_s    = 1'b1;
        err_v_raw_s = (v_len_s != 11'(P_V_TOTAL));
      end else if (rx_v_q != 10'd1023) begin
        rx_v_d = rx_v_q + 10'd1;
      end else begin
        rx_v_d = rx_v_q;
      end
    end else if (rx_h_q != 11'd2047) begin
      rx_h_d      = rx_h_q + 11'd1;
      // Reaching saturation means the sync went missing; flag it once
      err_h_raw_s = (rx_h_q == 11'd2046);
    end else begin
      rx_h_d = rx_h_q;
    end
  end

  // Lock FSM next state; errors are only reported once acquisition began
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_h_s = err_h_raw_s & (state_q != UNLOCKED);
    err_v_s = err_v_raw_s & (state_q != UNLOCKED);
    case (state_q)
      UNLOCKED: begin
        if (fstart_s) begin
          state_d = ACQUIRE;
          good_d  = 4'd0;
        end else begin
          state_d = UNLOCKED;
        end
      end
      ACQUIRE: begin
        if (err_h_s || err_v_s) begin
          state_d = UNLOCKED;
          good_d  = 4'd0;
        end else if (fstart_s) begin
          good_d = good_q + 4'd1;
          if (good_d == 4'(P_LOCK_FRAMES)) begin
            state_d = LOCKED;
          end else begin
            state_d = ACQUIRE;
          end
        end else begin
          state_d = ACQUIRE;
        end
      end
      LOCKED: begin
        if (err_h_s || err_v_s) begin
          state_d = UNLOCKED;
          good_d  = 4'd0;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = UNLOCKED;
        good_d  = 4'd0;
      end
    endcase
  end

  // Capture window decode; uses the post-update lock state so locked,
  // cap_valid and the error pulses change in the same output cycle
  always_comb begin
    lock_s  = (state_d == LOCKED);
    h_win_s = (rx_h_d >= 11'(P_H_START)) &&
              (rx_h_d <= 11'(P_H_START + P_H_ACTIVE - 1));
    v_win_s = (rx_v_d >= 10'(P_V_START)) &&
              (rx_v_d <= 10'(P_V_START + P_V_ACTIVE - 1));
    valid_s = lock_s & h_win_s & v_win_s;
    if (valid_s) begin
      x_s = rx_h_d - 11'(P_H_START);
      y_s = rx_v_d - 10'(P_V_START);
    end else begin
      x_s = 11'd0;
      y_s = 10'd0;
    end
  end

`ifdef VGA_IN_BLANK_CHECK_EN
  assign blank_s = lock_s & ~(h_win_s & v_win_s) & (rgb_q != 12'd0);
`else
  assign blank_s = 1'b0;
`endif

  // State registers and output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_h_q      <= 11'd0;
      rx_v_q      <= 10'd0;
      vpend_q     <= 1'b0;
      good_q      <= 4'd0;
      state_q     <= UNLOCKED;
      cap_x       <= 11'd0;
      cap_y       <= 10'd0;
      cap_rgb     <= 12'd0;
      cap_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      line_len    <= 11'd0;
      blank_err   <= 1'b0;
    end else begin
      rx_h_q      <= rx_h_d;
      rx_v_q      <= rx_v_d;
      vpend_q     <= vpend_d;
      good_q      <= good_d;
      state_q     <= state_d;
      cap_x       <= x_s;
      cap_y       <= y_s;
      cap_rgb     <= valid_s ? rgb_q : 12'd0;
      cap_valid   <= valid_s;
      frame_start <= valid_s && (x_s == 11'd0) && (y_s == 10'd0);
      locked      <= lock_s;
      err_h       <= err_h_s;
      err_v       <= err_v_s;
      line_len    <= hs_fall_s ? h_len_s[10:0] : line_len;
      blank_err   <= blank_s;
    end
  end

endmodule

// File: tb/tb_vga_in.sv
// tb_vga_in: scoreboard bench for vga_in on a scaled raster
// (40 x 10 total, 24 x 6 active starting at (8,2), hsync 4 samples,
// vsync 2 lines). The generator drives directed frames; at chosen raster
// positions the expected outputs (hand-derived) are queued with a due cycle
// two clocks later, and a monitor pops and compares them.
module tb_vga_in;

  localparam int HT = 40;
  localparam int VT = 10;
  localparam int HS = 4;
  localparam int VS = 2;
`ifdef VGA_IN_BLANK_CHECK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b0;
  logic [3:0]  pix_r = 4'd0, pix_g = 4'd0, pix_b = 4'd0;
  logic [10:0] cap_x;
  logic [9:0]  cap_y;
  logic [11:0] cap_rgb;
  logic        cap_valid, frame_start, locked, err_h, err_v, blank_err;
  logic [10:0] line_len;

  vga_in #(
    .P_H_TOTAL(HT), .P_V_TOTAL(VT), .P_H_START(8), .P_H_ACTIVE(24),
    .P_V_START(2), .P_V_ACTIVE(6), .P_LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .cap_x(cap_x), .cap_y(cap_y), .cap_rgb(cap_rgb), .cap_valid(cap_valid),
    .frame_start(frame_start), .locked(locked), .err_h(err_h), .err_v(err_v),
    .line_len(line_len), .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f; int hc; int vc;
    int lk; int vld; int x; int y; int rgb; int fs; int eh; int ev; int bl; int len;
    int due;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mon_v;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_eh = 0, n_ev = 0, n_fs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(int f, int hc, int vc, int lk, int vld, int x, int y,
                              int rgb, int fs, int eh, int ev, int bl, int len);
    vec_t v;
    v.f = f; v.hc = hc; v.vc = vc; v.lk = lk; v.vld = vld; v.x = x; v.y = y;
    v.rgb = rgb; v.fs = fs; v.eh = eh; v.ev = ev; v.bl = bl; v.len = len; v.due = 0;
    return v;
  endfunction

  // Generator colour: pattern inside the window, a few probes outside it
  function automatic logic [11:0] rgb_at(int hc, int vc);
    logic [5:0] h6;
    logic [3:0] v4;
    h6 = hc[5:0];
    v4 = vc[3:0];
    if (hc == 8 && vc == 2) return 12'hA5C;
    if (hc >= 8 && hc <= 31 && vc >= 2 && vc <= 7) return {h6, v4, 2'b01};
    if ((hc == 7 && vc == 2) || (hc == 32 && vc == 7)) return 12'h123;
    if (hc == 2 && vc == 4) return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic chk(string nm, string fld, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  task automatic run_line(input int f, input int vc, input int h0, input int len, input bit vs_en);
    vec_t it;
    for (int hc = h0; hc < len; hc++) begin
      @(negedge clk);
      rst   = 1'b0;
      hsync = (hc < HS) ? 1'b0 : 1'b1;
      vsync = (vs_en && vc < VS) ? 1'b1 : 1'b0;
      {pix_r, pix_g, pix_b} = rgb_at(hc, vc);
      foreach (vecs[i]) begin
        if (vecs[i].f == f && vecs[i].hc == hc && vecs[i].vc == vc) begin
          it = vecs[i];
          it.due = cyc + 2;
          exp_q.push_back(it);
        end
      end
    end
  endtask

  // Monitor: compare every queued expectation on its due cycle, count pulses
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      string nm;
      mon_v = exp_q.pop_front();
      nm = $sformatf("f%0d(%0d,%0d)", mon_v.f, mon_v.hc, mon_v.vc);
      chk(nm, "locked", int'(locked), mon_v.lk);
      chk(nm, "cap_valid", int'(cap_valid), mon_v.vld);
      chk(nm, "cap_x", int'(cap_x), mon_v.x);
      chk(nm, "cap_y", int'(cap_y), mon_v.y);
      chk(nm, "cap_rgb", int'(cap_rgb), mon_v.rgb);
      chk(nm, "frame_start", int'(frame_start), mon_v.fs);
      chk(nm, "err_h", int'(err_h), mon_v.eh);
      chk(nm, "err_v", int'(err_v), mon_v.ev);
      chk(nm, "blank_err", int'(blank_err), mon_v.bl);
      if (mon_v.len >= 0) chk(nm, "line_len", int'(line_len), mon_v.len);
    end
    if (err_h) n_eh++;
    if (err_v) n_ev++;
    if (frame_start) n_fs++;
  end

  initial begin
    vec_t r;
    //            f  hc vc lk vld x  y  rgb     fs eh ev bl  len
    vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(1,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(2,  0, 0, 1, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(2,  0, 1, 1, 0, 0, 0, 0,      0, 0, 0, 0, 40));
    vecs.push_back(mk(2,  7, 2, 1, 0, 0, 0, 0,      0, 0, 0, BL, -1));
    vecs.push_back(mk(2,  8, 2, 1, 1, 0, 0, 'hA5C,  1, 0, 0, 0, -1));
    vecs.push_back(mk(2,  2, 4, 1, 0, 0, 0, 0,      0, 0, 0, BL, -1));
    vecs.push_back(mk(2, 31, 7, 1, 1, 23, 5, 'h7DD, 0, 0, 0, 0, -1));
    vecs.push_back(mk(2, 32, 7, 1, 0, 0, 0, 0,      0, 0, 0, BL, -1));
    vecs.push_back(mk(2,  8, 8, 1, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(3,  8, 2, 1, 1, 0, 0, 'hA5C,  1, 0, 0, 0, -1));
    vecs.push_back(mk(3,  0, 5, 0, 0, 0, 0, 0,      0, 1, 0, 0, 39));
    vecs.push_back(mk(3,  8, 6, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(4,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(4,  0, 1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 40));
    vecs.push_back(mk(5,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(6,  0, 0, 1, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(6,  8, 2, 1, 1, 0, 0, 'hA5C,  1, 0, 0, 0, -1));
    vecs.push_back(mk(7,  0, 0, 1, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(7,  8, 2, 1, 0, 0, 0, 0,      0, 0, 0, BL, -1));
    vecs.push_back(mk(8,  0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 0, -1));
    vecs.push_back(mk(8,  8, 2, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(9,  0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(11, 0, 0, 1, 0, 0, 0, 0,      0, 0, 0, 0, -1));
    vecs.push_back(mk(11, 8, 2, 1, 1, 0, 0, 'hA5C,  1, 0, 0, 0, -1));

    // Reset with random pins: everything must read zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst   = 1'b1;
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      {pix_r, pix_g, pix_b} = 12'($urandom);
      r = mk(-1, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      r.due = cyc + 1;
      exp_q.push_back(r);
    end

    // Tail of a previous frame so the first frame start is seen cleanly
    run_line(-1, VT - 1, HS, HT, 1'b1);

    // f3: line 4 one sample short; f7: vsync pulse suppressed
    for (int f = 0; f < 12; f++) begin
      for (int vc = 0; vc < VT; vc++) begin
        run_line(f, vc, 0, (f == 3 && vc == 4) ? HT - 1 : HT, (f != 7));
      end
    end

    repeat (4) @(negedge clk);
    chk("end", "pending", exp_q.size(), 0);
    chk("end", "err_h_count", n_eh, 1);
    chk("end", "err_v_count", n_ev, 1);
    chk("end", "frame_start_count", n_fs, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_in.md
# vga_in

Receive-side VGA raster decoder for loopback and self-test of the 1280x800 video path. Samples the `hsync`/`vsync`/RGB lines produced by the display timing generator, recovers pixel coordinates, checks line and frame lengths against the fixed raster, and asserts `locked` after consecutive clean frames. Sits on the same pixel clock as the display output, feeding capture/CRC logic.

## Interface
- `H_TOTAL`, 1680: samples per line
- `V_TOTAL`, 828: lines per frame
- `H_START`, 336: first active sample after the `hsync` falling edge
- `H_ACTIVE`, 1280: active samples per line
- `V_START`, 27: first active line after the frame start
- `V_ACTIVE`, 800: active lines per frame
- `LOCK_FRAMES`, 2: consecutive clean frames required to lock

- `clk`  in  1  pixel clock
- `rst`  in  1  reset, synchronous, active-high
- `hsync`  in  1  line sync, active-low
- `vsync`  in  1  frame sync, active-high
- `pix_r`/`pix_g`/`pix_b`  in  4 each  pixel colour
- `cap_x`  out  11  active column, 0..1279
- `cap_y`  out  10  active row, 0..799
- `cap_rgb`  out  12  `{r,g,b}` of the captured sample
- `cap_valid`  out  1  `cap_*` is an active pixel
- `frame_start`  out  1  one-cycle pulse with pixel (0,0)
- `locked`  out  1  raster lock
- `err_h`  out  1  one-cycle pulse on a bad line length
- `err_v`  out  1  one-cycle pulse on a bad frame length
- `line_len`  out  11  last measured line length
- `blank_err`  out  1  one-cycle pulse on non-zero RGB in blanking

## Operation
- Stage 1 registers all inputs. The edge detector compares each stage-1 sample with the previous one.
- `rx_h`:
  - Set to 0 on the sample where `hsync` falls.
  - Otherwise increments, saturating at 2047.
  - Saturation counts as a missing sync: `err_h` fires (when not UNLOCKED).
- On each `hsync` fall:
  - `line_len <= rx_h+1`.
  - If `rx_h+1 != H_TOTAL`, `err_h` fires.
- A `vsync` rise sets `vpend`. This includes a rise on the same sample as the `hsync` fall.
- `rx_v` updates on each `hsync` fall:
  - If `vpend` is set: `rx_v` goes to 0 and `vpend` clears. This is a frame start. If the previous `rx_v+1 != V_TOTAL`, `err_v` fires.
  - Otherwise `rx_v` increments, saturating at 1023.
- Lock FSM:
  - UNLOCKED: counters run, error pulses are suppressed. Go to ACQUIRE at the first frame start, with `good=0`.
  - ACQUIRE: at each frame start, `good++`. When `good == LOCK_FRAMES`, go to LOCKED.
  - LOCKED: `locked=1`.
  - In ACQUIRE or LOCKED, any `err_h` or `err_v` goes to UNLOCKED and clears `good`.
- `cap_valid = locked && rx_h in [H_START, H_START+H_ACTIVE-1] && rx_v in [V_START, V_START+V_ACTIVE-1]`.
- When valid: `cap_x = rx_h-H_START` and `cap_y = rx_v-V_START`. Otherwise both are 0.
- `cap_rgb` passes the sample through; it is 0 when not valid.
- `frame_start` pulses when `cap_valid && cap_x==0 && cap_y==0`.

## Timing
- Reset values: every output is 0 and the FSM is UNLOCKED. `rx_h`, `rx_v`, `good` and `vpend` are all 0.
- Latency from input pins to `cap_*`, `frame_start`, `err_*` and `blank_err` is 2 cycles: input register, then output register.
- `locked` changes in the same output cycle as the frame-start evaluation that caused the change.
- `locked` falls in the same cycle that `err_h` or `err_v` pulses.
- Reset mid-frame: all state clears immediately. Relock needs the first frame start plus `LOCK_FRAMES` full frames.

## Configuration
- `VGA_IN_BLANK_CHECK_EN` defined:
  - `blank_err` pulses when `locked`, the sample is outside the active window, and RGB != 0.
  - Lock state is not affected.
- Not defined: `blank_err` is tied to 0 and the comparator is omitted. The port is present in both configurations.

## Structure
- `vga_pkg` holds:
  - raster constants: `H_TOTAL`, `V_TOTAL`, `H_SYNC=136`, `V_SYNC=3`, `H_START`, `V_START`, `H_ACTIVE`, `V_ACTIVE`
  - the `lock_state_t` enum `{UNLOCKED, ACQUIRE, LOCKED}`
- Sub-module `vga_sync_edge`: one input flop plus previous-value flop, producing `rise`/`fall` pulses. Instantiated for `hsync` and for `vsync`.

## Test plan
- Reset: drive `rst` for 3 cycles with random inputs -> all outputs 0, `locked=0`.
- Clean loopback from the display timing generator -> `locked` rises at the 3rd frame start (first frame start plus 2 clean frames); no `err_*` pulses.
- Locked; generator at hcount=336, vcount=27 with RGB=12'hA5C -> 2 cycles later `cap_valid=1`, `cap_x=0`, `cap_y=0`, `cap_rgb=12'hA5C`, `frame_start=1`. At hcount=1615, vcount=826 -> `cap_x=1279`, `cap_y=799`.
- Locked; shorten one line to 1679 samples -> `err_h` pulse, `line_len=1679`, `locked=0`. Relock after 2 further clean frames.
- Locked; suppress one `vsync` pulse -> `err_v` at the next frame start (line count 1656), `locked=0`.
- With `VGA_IN_BLANK_CHECK_EN`: locked, RGB=12'hFFF at hcount=100 -> `blank_err` pulse. Without the macro, same stimulus -> `blank_err=0`.
